uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_counter.sv | 32 +++
 rtl/uart_rx_ctrl.sv | 138 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM state encodings and frame defaults,
// common to the receive and transmit controllers.
package uart_pkg;

    // Default number of data bits carried in one frame.
    localparam int UART_DATA_BITS_DEFAULT = 8;

    // One-hot controller states; any other pattern is treated as illegal.
    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_START   = 4'b0010,
        S_READING = 4'b0100,
        S_STOP    = 4'b1000
    } uart_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts clk cycles from an explicit clear and flags the
// half-period and full-period points. It never wraps on its own; it parks at
// the full-period value until the owner clears it.
module uart_baud_counter #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic half_hit,
    output logic full_hit
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count up from the last clear, holding at the full-period value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt != FULL_LAST) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign half_hit = (cnt == HALF_LAST);
    assign full_hit = (cnt == FULL_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes rx, detects the start edge, samples
// each data bit mid-period, checks the stop bit and presents the byte.
//
// Output strobes: valid and frame_err are single-cycle pulses with no
// back-pressure (there is no ready). data is stable from the valid cycle
// until the next valid, so a consumer captures it in the cycle valid is high.
// The two strobes are mutually exclusive.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV          = 16,
    parameter int DATA_BYTE_LENGTH = UART_DATA_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy,
    output logic [3:0] state
);

    if (CLK_DIV < 4) begin : g_bad_clk_div
        $error("uart_rx_ctrl: CLK_DIV must be >= 4");
    end
    if (DATA_BYTE_LENGTH < 1 || DATA_BYTE_LENGTH > 8) begin : g_bad_data_len
        $error("uart_rx_ctrl: DATA_BYTE_LENGTH must be 1..8");
    end

    localparam logic [2:0] LAST_BIT = 3'(DATA_BYTE_LENGTH - 1);

    uart_state_e state_q;
    logic        rx_meta;
    logic        rx_s;
    logic        rx_s_d;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
    logic        baud_clr;
    logic        half_hit;
    logic        full_hit;

    assign state = state_q;
    assign busy  = (state_q != S_IDLE);

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Restart the bit-period count while idle and at every sampling point.
    always_comb begin
        baud_clr = 1'b0;
        case (state_q)
            S_IDLE:            baud_clr = 1'b1;
            S_START:           baud_clr = half_hit;
            S_READING, S_STOP: baud_clr = full_hit;
            default:           baud_clr = 1'b1;
        endcase
    end

    uart_baud_counter #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (baud_clr),
        .half_hit (half_hit),
        .full_hit (full_hit)
    );

    // Frame FSM with shift register and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
            shift_q   <= '0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_s_d && !rx_s) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (half_hit) begin
                        if (!rx_s) begin
                            state_q <= S_READING;
                            bit_cnt <= '0;
                            shift_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_READING: begin
                    if (full_hit) begin
                        shift_q[bit_cnt] <= rx_s;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state_q <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (full_hit) begin
                        state_q <= S_IDLE;
                        if (rx_s) begin
                            data  <= shift_q;
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a CLK_DIV=16 / 8-bit instance carries the
// main scenarios, a CLK_DIV=5 / 7-bit instance checks the odd configuration.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] data_a;
    logic       valid_a;
    logic       ferr_a;
    logic       busy_a;
    logic [3:0] state_a;
    logic [7:0] data_b;
    logic       valid_b;
    logic       ferr_b;
    logic       busy_b;
    logic [3:0] state_b;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    int cyc          = 0;
    int start_cyc_a  = 0;
    int start_cnt_a  = 0;
    int glitch_cnt_a = 0;
    int valid_cnt_a  = 0;
    int ferr_cnt_a   = 0;
    int start_cyc_b  = 0;
    int valid_cnt_b  = 0;
    int ferr_cnt_b   = 0;
    int lat_b        = 0;
    logic [7:0] last_data_b = 8'h00;
    logic [3:0] prev_state_a = 4'b0001;
    logic [3:0] prev_state_b = 4'b0001;

    int s0, g0, v0, f0;

    uart_rx_ctrl #(.CLK_DIV(16), .DATA_BYTE_LENGTH(8)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_a),
        .data      (data_a),
        .valid     (valid_a),
        .frame_err (ferr_a),
        .busy      (busy_a),
        .state     (state_a)
    );

    uart_rx_ctrl #(.CLK_DIV(5), .DATA_BYTE_LENGTH(7)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_b),
        .data      (data_b),
        .valid     (valid_b),
        .frame_err (ferr_b),
        .busy      (busy_b),
        .state     (state_b)
    );

    // Clock / reset block.
    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: called aligned to a falling clk edge.
    task automatic drive_rx(input int which, input logic v, input int cycles);
        if (which == 0) rx_a = v;
        else            rx_b = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input int div, input int len,
                              input logic [7:0] d, input logic stop_bit);
        drive_rx(which, 1'b0, div);
        for (int i = 0; i < len; i++) drive_rx(which, d[i], div);
        drive_rx(which, stop_bit, div);
    endtask

    // Monitor and scoreboard, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (state_a == 4'b0010 && prev_state_a != 4'b0010) begin
                start_cnt_a++;
                start_cyc_a = cyc;
            end
            if (state_a == 4'b0001 && prev_state_a == 4'b0010) glitch_cnt_a++;
            if (valid_a || ferr_a) begin
                check_eq("a_excl", {31'b0, valid_a & ferr_a}, 32'd0);
                check_eq("a_latency", 32'(cyc - start_cyc_a), 32'd152);
            end
            if (valid_a) begin
                valid_cnt_a++;
                check_eq("a_q_empty", {31'b0, exp_q.size() == 0}, 32'd0);
                if (exp_q.size() != 0) check_eq("a_data", 32'(data_a), 32'(exp_q.pop_front()));
            end
            if (ferr_a) ferr_cnt_a++;
            prev_state_a = state_a;

            if (state_b == 4'b0010 && prev_state_b != 4'b0010) start_cyc_b = cyc;
            if (valid_b) begin
                valid_cnt_b++;
                last_data_b = data_b;
                lat_b = cyc - start_cyc_b;
            end
            if (ferr_b) ferr_cnt_b++;
            prev_state_b = state_b;
        end
    end

    initial begin
        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (4) @(negedge clk);

        // Reset values.
        check_eq("rst_state_a", 32'(state_a), 32'h1);
        check_eq("rst_data_a",  32'(data_a),  32'h0);
        check_eq("rst_valid_a", 32'(valid_a), 32'h0);
        check_eq("rst_ferr_a",  32'(ferr_a),  32'h0);
        check_eq("rst_busy_a",  32'(busy_a),  32'h0);
        check_eq("rst_state_b", 32'(state_b), 32'h1);
        check_eq("rst_busy_b",  32'(busy_b),  32'h0);
        rst = 1'b0;
        drive_rx(0, 1'b1, 20);

        // Good frame 0xA5.
        exp_q.push_back(8'hA5);
        send_frame(0, 16, 8, 8'hA5, 1'b1);
        drive_rx(0, 1'b1, 20);
        check_eq("a5_valid_cnt", 32'(valid_cnt_a), 32'd1);
        check_eq("a5_ferr_cnt",  32'(ferr_cnt_a),  32'd0);
        check_eq("a5_data",      32'(data_a),      32'hA5);

        // Short low glitch: START then back to IDLE, no strobes.
        s0 = start_cnt_a;
        g0 = glitch_cnt_a;
        drive_rx(0, 1'b0, 4);
        drive_rx(0, 1'b1, 40);
        check_eq("gl_starts",    32'(start_cnt_a - s0),  32'd1);
        check_eq("gl_to_idle",   32'(glitch_cnt_a - g0), 32'd1);
        check_eq("gl_valid_cnt", 32'(valid_cnt_a), 32'd1);
        check_eq("gl_ferr_cnt",  32'(ferr_cnt_a),  32'd0);
        check_eq("gl_data",      32'(data_a),      32'hA5);
        check_eq("gl_state",     32'(state_a),     32'h1);

        // 0x3C with low stop bit, then line held low (break).
        s0 = start_cnt_a;
        send_frame(0, 16, 8, 8'h3C, 1'b0);
        drive_rx(0, 1'b0, 100);
        check_eq("fe_ferr_cnt",  32'(ferr_cnt_a),  32'd1);
        check_eq("fe_valid_cnt", 32'(valid_cnt_a), 32'd1);
        check_eq("fe_data",      32'(data_a),      32'hA5);
        check_eq("fe_no_retrig", 32'(start_cnt_a - s0), 32'd1);
        check_eq("fe_state",     32'(state_a),     32'h1);
        check_eq("fe_busy",      32'(busy_a),      32'h0);
        drive_rx(0, 1'b1, 20);
        exp_q.push_back(8'h81);
        send_frame(0, 16, 8, 8'h81, 1'b1);
        drive_rx(0, 1'b1, 20);
        check_eq("fe_recover_cnt",  32'(valid_cnt_a), 32'd2);
        check_eq("fe_recover_data", 32'(data_a),      32'h81);

        // Reset pulse in the middle of bit 4 of a 0xFF frame.
        s0 = start_cnt_a;
        v0 = valid_cnt_a;
        f0 = ferr_cnt_a;
        drive_rx(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive_rx(0, 1'b1, 16);
        drive_rx(0, 1'b1, 8);
        rst = 1'b1;
        @(negedge clk);
        check_eq("ab_state", 32'(state_a), 32'h1);
        check_eq("ab_busy",  32'(busy_a),  32'h0);
        check_eq("ab_valid", 32'(valid_a), 32'h0);
        check_eq("ab_ferr",  32'(ferr_a),  32'h0);
        rst = 1'b0;
        drive_rx(0, 1'b1, 200);
        check_eq("ab_starts",    32'(start_cnt_a - s0), 32'd1);
        check_eq("ab_valid_cnt", 32'(valid_cnt_a - v0), 32'd0);
        check_eq("ab_ferr_cnt",  32'(ferr_cnt_a - f0),  32'd0);
        check_eq("ab_data",      32'(data_a),           32'h0);
        exp_q.push_back(8'h5A);
        send_frame(0, 16, 8, 8'h5A, 1'b1);
        drive_rx(0, 1'b1, 20);
        check_eq("ab_next_cnt",  32'(valid_cnt_a - v0), 32'd1);
        check_eq("ab_next_data", 32'(data_a),           32'h5A);

        // Back-to-back 0x00 then 0xFF with one stop bit and no gap.
        v0 = valid_cnt_a;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(0, 16, 8, 8'h00, 1'b1);
        send_frame(0, 16, 8, 8'hFF, 1'b1);
        drive_rx(0, 1'b1, 20);
        check_eq("b2b_valid_cnt", 32'(valid_cnt_a - v0), 32'd2);
        check_eq("b2b_data",      32'(data_a),           32'hFF);
        check_eq("b2b_q_left",    32'(exp_q.size()),     32'd0);
        check_eq("a_ferr_total",  32'(ferr_cnt_a),       32'd1);

        // CLK_DIV=5, 7 data bits, 0x55.
        send_frame(1, 5, 7, 8'h55, 1'b1);
        drive_rx(1, 1'b1, 20);
        check_eq("b_valid_cnt", 32'(valid_cnt_b), 32'd1);
        check_eq("b_data",      32'(last_data_b), 32'h55);
        check_eq("b_latency",   32'(lat_b),       32'd42);
        check_eq("b_ferr_cnt",  32'(ferr_cnt_b),  32'd0);
        check_eq("b_state",     32'(state_b),     32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
